// File: rtl/axis_mem_streamer_if.sv
// AXI4-Stream beat channel used by axis_mem_streamer (master side drives data/valid/last).
interface axis_mem_streamer_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic                    tlast;
  logic                    tvalid;
  logic                    tready;

  modport master (output tdata, tstrb, tlast, tvalid, input tready);
  modport slave  (input tdata, tstrb, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_mem_streamer.sv
// AXI4-Stream master streaming LENGTH words from a synchronous source memory through a credit-based prefetch FIFO.
// Defining STREAMER_ABORT_EN adds an abort input that truncates the packet in progress.
module axis_mem_streamer #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int SRC_LATENCY = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
`ifdef STREAMER_ABORT_EN
  input  logic                  abort,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] src_addr,
  output logic                  src_enable,
  input  logic [DATA_WIDTH-1:0] src_data,
  axis_mem_streamer_if.master   m_axis
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = $clog2(FIFO_DEPTH + SRC_LATENCY + 1) + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]             state;
  logic [ADDR_WIDTH-1:0]  base_r;
  logic [ADDR_WIDTH:0]    len_r;
  logic [ADDR_WIDTH:0]    issued;
  logic [SRC_LATENCY-1:0] vld_sr;
  logic [SRC_LATENCY-1:0] last_sr;
  logic [DATA_WIDTH-1:0]  fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]  fifo_last;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;
  logic                   abort_hold;
  logic                   abort_wait;

  logic                   abort_now;
  logic                   abort_start;
  logic                   tvalid;
  logic                   tlast;
  logic                   pop;
  logic                   finish;
  logic                   abort_empty;
  logic                   discard;
  logic                   waiting;
  logic                   push;
  logic                   push_last;
  logic [SUM_W-1:0]       in_flight;

`ifdef STREAMER_ABORT_EN
  assign abort_now = abort && (state == ST_RUN);
`else
  assign abort_now = 1'b0;
`endif

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < SRC_LATENCY; i++) begin
      in_flight = in_flight + SUM_W'(vld_sr[i]);
    end
  end

  // Abort modes: hold keeps only the FIFO head and forces its tlast; wait tags the first returning read as last.
  assign abort_start = abort_now && !abort_hold && !abort_wait;
  assign tvalid      = (count != '0);
  assign tlast       = tvalid && (fifo_last[rd_ptr] || abort_hold || abort_start);
  assign pop         = tvalid && m_axis.tready;
  assign finish      = pop && tlast;
  assign abort_empty = abort_start && !tvalid && (in_flight == '0);
  assign discard     = abort_hold || (abort_start && tvalid);
  assign waiting     = abort_wait || (abort_start && !tvalid);
  assign push        = vld_sr[SRC_LATENCY-1] && !discard;
  assign push_last   = last_sr[SRC_LATENCY-1] || waiting;

  assign src_enable = (state == ST_RUN) && (issued < len_r) && !abort_now && !abort_hold &&
                      !abort_wait && ((in_flight + SUM_W'(count)) < SUM_W'(FIFO_DEPTH));
  assign src_addr   = base_r + issued[ADDR_WIDTH-1:0];
  assign busy       = (state == ST_RUN);

  assign m_axis.tvalid = tvalid;
  assign m_axis.tlast  = tlast;
  assign m_axis.tdata  = tvalid ? fifo_data[rd_ptr] : '0;
  assign m_axis.tstrb  = {(DATA_WIDTH/8){tvalid}};

  always_ff @(posedge aclk) begin
    if (push) begin
      fifo_data[wr_ptr] <= src_data;
      fifo_last[wr_ptr] <= push_last;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state      <= ST_IDLE;
      base_r     <= '0;
      len_r      <= '0;
      issued     <= '0;
      vld_sr     <= '0;
      last_sr    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      abort_hold <= 1'b0;
      abort_wait <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE) begin
        if (start) begin
          base_r <= base_addr;
          len_r  <= length;
          issued <= '0;
          if (length != '0) state <= ST_RUN;
          else              done  <= 1'b1;
        end
      end else if (finish || abort_empty) begin
        state      <= ST_IDLE;
        done       <= 1'b1;
        vld_sr     <= '0;
        last_sr    <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
        abort_hold <= 1'b0;
        abort_wait <= 1'b0;
      end else begin
        if (src_enable) issued <= issued + 1'b1;
        for (int i = SRC_LATENCY - 1; i > 0; i--) begin
          vld_sr[i]  <= vld_sr[i-1];
          last_sr[i] <= last_sr[i-1];
        end
        vld_sr[0]  <= src_enable;
        last_sr[0] <= src_enable && (issued == len_r - 1'b1);
        // Entering or staying in hold: drop in-flight reads and collapse the FIFO to its head entry.
        if (discard) begin
          abort_hold <= 1'b1;
          abort_wait <= 1'b0;
          vld_sr     <= '0;
          last_sr    <= '0;
          wr_ptr     <= rd_ptr + 1'b1;
          count      <= CNT_W'(1);
        end else if (waiting && push) begin
          abort_hold <= 1'b1;
          abort_wait <= 1'b0;
          vld_sr     <= '0;
          last_sr    <= '0;
          wr_ptr     <= wr_ptr + 1'b1;
          count      <= count + 1'b1;
        end else begin
          abort_wait <= waiting;
          if (push) wr_ptr <= wr_ptr + 1'b1;
          if (pop)  rd_ptr <= rd_ptr + 1'b1;
          count <= count + CNT_W'(push) - CNT_W'(pop);
        end
      end
    end
  end
endmodule

// File: tb/tb_axis_mem_streamer.sv
// Bench for axis_mem_streamer: random memory image, directed packets checked against a queue of expected beats.
`timescale 1ns/1ps
module tb_axis_mem_streamer;
  localparam int DW        = 32;
  localparam int AW        = 12;
  localparam int LAT       = 1;
  localparam int DEPTH     = 4;
  localparam int MEM_WORDS = 1 << AW;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
`ifdef STREAMER_ABORT_EN
  logic          abort = 1'b0;
`endif
  logic          busy;
  logic          done;
  logic          src_enable;
  logic [AW-1:0] src_addr;
  logic [DW-1:0] src_data;

  logic [DW-1:0] mem [MEM_WORDS];
  logic [DW-1:0] rd_pipe [LAT];
  logic [AW-1:0] read_log [$];
  int            compared = 0;
  int            mismatched = 0;

  axis_mem_streamer_if #(.DATA_WIDTH(DW)) axis_if ();

  axis_mem_streamer #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .SRC_LATENCY(LAT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
`ifdef STREAMER_ABORT_EN
    .abort     (abort),
`endif
    .busy      (busy),
    .done      (done),
    .src_addr  (src_addr),
    .src_enable(src_enable),
    .src_data  (src_data),
    .m_axis    (axis_if)
  );

  always #5 aclk = ~aclk;

  // Source memory: data for a strobe appears LAT cycles later; every strobe is logged.
  assign src_data = rd_pipe[LAT-1];
  always @(posedge aclk) begin
    rd_pipe[0] <= mem[src_addr];
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (src_enable === 1'b1) read_log.push_back(src_addr);
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Launch one packet, drive tready per mode (0 steady, 1 pattern 1,0,0,1, 2 random) and check every beat.
  task automatic applyStimulus(input logic [AW-1:0] base, input int len, input int mode,
                               input int restart_at, input string tag);
    logic [DW-1:0] exp_data [$];
    logic [AW-1:0] exp_addr [$];
    int            beat = 0;
    int            cyc = 0;
    int            first_valid = -1;
    int            last_hs = -1;
    int            done_cyc = -1;
    int            done_cnt = 0;
    int            max_out = 0;
    int            idle_bad = 0;
    bit            stall_prev = 1'b0;
    bit            stable_ok = 1'b1;
    bit            strb_ok = 1'b1;
    logic [DW-1:0] held_data = '0;
    logic          held_last = 1'b0;
    for (int i = 0; i < len; i++) begin
      exp_addr.push_back(AW'(int'(base) + i));
      exp_data.push_back(mem[AW'(int'(base) + i)]);
    end
    read_log.delete();
    base_addr      = base;
    length         = len[AW:0];
    start          = 1'b1;
    axis_if.tready = 1'b0;
    step();
    start = 1'b0;
    cyc   = 1;
    while ((beat < len || done_cyc < 0) && cyc < len * 8 + 50) begin
      if (cyc == restart_at) begin
        start     = 1'b1;
        base_addr = ~base;
        length    = 5;
      end else begin
        start = 1'b0;
      end
      case (mode)
        0:       axis_if.tready = 1'b1;
        1:       axis_if.tready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: axis_if.tready = 1'($urandom_range(0, 1));
      endcase
      if (read_log.size() - beat > max_out) max_out = read_log.size() - beat;
      if (axis_if.tvalid && first_valid < 0) first_valid = cyc;
      if (stall_prev && !(axis_if.tvalid === 1'b1 && axis_if.tdata === held_data &&
                          axis_if.tlast === held_last)) stable_ok = 1'b0;
      if (axis_if.tvalid && axis_if.tstrb !== '1) strb_ok = 1'b0;
      if (axis_if.tvalid && axis_if.tready) begin
        if (beat < len) begin
          checkOutput($sformatf("%s_data%0d", tag, beat), axis_if.tdata, exp_data[beat]);
          checkOutput($sformatf("%s_last%0d", tag, beat), axis_if.tlast, beat == len - 1);
        end else begin
          checkOutput($sformatf("%s_extra_beat", tag), beat, len);
        end
        beat++;
        last_hs = cyc;
      end
      stall_prev = axis_if.tvalid && !axis_if.tready;
      held_data  = axis_if.tdata;
      held_last  = axis_if.tlast;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      step();
      cyc++;
    end
    start = 1'b0;
    checkOutput({tag, "_beats"}, beat, len);
    checkOutput({tag, "_done_cycle"}, done_cyc, (len == 0) ? 1 : last_hs + 1);
    if (len > 0) checkOutput({tag, "_first_latency"}, first_valid, LAT + 2);
    else         checkOutput({tag, "_no_valid"}, first_valid, -1);
    if (mode == 0 && len > 0) checkOutput({tag, "_no_gaps"}, last_hs - first_valid, len - 1);
    checkOutput({tag, "_stable"}, stable_ok, 1'b1);
    checkOutput({tag, "_tstrb"}, strb_ok, 1'b1);
    checkOutput({tag, "_outstanding_le_depth"}, max_out <= DEPTH, 1'b1);
    checkOutput({tag, "_read_count"}, read_log.size(), len);
    for (int i = 0; i < len && i < read_log.size(); i++) begin
      checkOutput($sformatf("%s_addr%0d", tag, i), read_log[i], exp_addr[i]);
    end
    for (int k = 0; k < 5; k++) begin
      if (done) done_cnt++;
      if (axis_if.tvalid || busy) idle_bad++;
      step();
    end
    checkOutput({tag, "_done_once"}, done_cnt, 1);
    checkOutput({tag, "_idle_after"}, idle_bad, 0);
  endtask

  initial begin
    int beats;
    int guard;
    int bad;
    logic [AW-1:0] rbase;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
    axis_if.tready = 1'b0;
    aresetn        = 1'b0;
    step();
    step();
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_src_enable", src_enable, 1'b0);
    checkOutput("rst_src_addr", src_addr, '0);
    checkOutput("rst_tvalid", axis_if.tvalid, 1'b0);
    checkOutput("rst_tlast", axis_if.tlast, 1'b0);
    checkOutput("rst_tdata", axis_if.tdata, '0);
    aresetn = 1'b1;
    step();

    applyStimulus(12'h010, 8, 0, 4, "t1_basic");
    applyStimulus(AW'($urandom), 16, 1, -1, "t2_backpressure");
    applyStimulus(12'hFFE, 4, 0, -1, "t3_wrap");
    applyStimulus(12'h123, 0, 0, -1, "t4_zero");

    // Packet abandoned by a one-cycle reset right after its third beat.
    rbase          = AW'($urandom);
    read_log.delete();
    base_addr      = rbase;
    length         = 10;
    start          = 1'b1;
    axis_if.tready = 1'b1;
    step();
    start = 1'b0;
    beats = 0;
    guard = 0;
    while (beats < 3 && guard < 100) begin
      if (axis_if.tvalid && axis_if.tready) begin
        checkOutput($sformatf("t5_pre_data%0d", beats), axis_if.tdata, mem[AW'(int'(rbase) + beats)]);
        beats++;
      end
      step();
      guard++;
    end
    checkOutput("t5_reached_beat3", beats, 3);
    axis_if.tready = 1'b0;
    aresetn        = 1'b0;
    step();
    checkOutput("t5_rst_tvalid", axis_if.tvalid, 1'b0);
    checkOutput("t5_rst_tlast", axis_if.tlast, 1'b0);
    checkOutput("t5_rst_tdata", axis_if.tdata, '0);
    checkOutput("t5_rst_busy", busy, 1'b0);
    checkOutput("t5_rst_done", done, 1'b0);
    checkOutput("t5_rst_src_enable", src_enable, 1'b0);
    checkOutput("t5_rst_src_addr", src_addr, '0);
    aresetn        = 1'b1;
    axis_if.tready = 1'b1;
    bad            = 0;
    for (int k = 0; k < 6; k++) begin
      if (done || axis_if.tvalid || axis_if.tlast) bad++;
      step();
    end
    checkOutput("t5_quiet_after_reset", bad, 0);
    applyStimulus(AW'($urandom), 10, 0, -1, "t5_restart");

    applyStimulus(AW'($urandom), $urandom_range(1, 40), 2, -1, "rand_a");
    applyStimulus(AW'($urandom), $urandom_range(1, 40), 2, -1, "rand_b");
    applyStimulus(AW'($urandom), MEM_WORDS, 0, -1, "full_range");

`ifdef STREAMER_ABORT_EN
    // Abort while beat 5 of 20 is stalled: it is held, completes as last, and nothing follows.
    rbase          = AW'($urandom);
    base_addr      = rbase;
    length         = 20;
    start          = 1'b1;
    axis_if.tready = 1'b1;
    step();
    start = 1'b0;
    beats = 0;
    guard = 0;
    while (beats < 4 && guard < 100) begin
      if (axis_if.tvalid && axis_if.tready) beats++;
      step();
      guard++;
    end
    checkOutput("t6_reached_beat4", beats, 4);
    axis_if.tready = 1'b0;
    abort          = 1'b1;
    checkOutput("t6_b5_valid", axis_if.tvalid, 1'b1);
    checkOutput("t6_b5_data", axis_if.tdata, mem[AW'(int'(rbase) + 4)]);
    checkOutput("t6_b5_last_forced", axis_if.tlast, 1'b1);
    step();
    abort = 1'b0;
    checkOutput("t6_hold_valid", axis_if.tvalid, 1'b1);
    checkOutput("t6_hold_data", axis_if.tdata, mem[AW'(int'(rbase) + 4)]);
    checkOutput("t6_hold_last", axis_if.tlast, 1'b1);
    checkOutput("t6_issue_stopped", src_enable, 1'b0);
    step();
    axis_if.tready = 1'b1;
    checkOutput("t6_hs_data", axis_if.tdata, mem[AW'(int'(rbase) + 4)]);
    checkOutput("t6_hs_last", axis_if.tlast, 1'b1);
    step();
    checkOutput("t6_done", done, 1'b1);
    checkOutput("t6_busy_clear", busy, 1'b0);
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      if (axis_if.tvalid) bad++;
      step();
      if (done) bad++;
    end
    checkOutput("t6_no_more_beats", bad, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
